uart_frame_scheduler: RTL and testbench
=======================================

// Module: uart_frame_scheduler
// PURPOSE
// - Shares the single UART transmitter between all game-state producers of the gameplay pipeline.
// - Producers: tank position/direction, our bullet, hit/obstacle events, enemy HP.
// - On each frame tick, snapshots all fields, packs them into a 9-byte packet and sequences it byte-by-byte into the UART TX.
// - Sits between the tank/gun logic outputs and uart_tx.
// PARAMETERS
// - SYNC_BYTE   8'hA5  first byte of every packet
// - FRAME_DIV   1      send one packet every FRAME_DIV vsync rising edges (1..15)
// PORTS
// - clk                 in   1   system clock
// - rst                 in   1   asynchronous, active-low reset (0 = reset)
// - vsync               in   1   frame sync; rising edge = frame tick
// - xpos_tank, ypos_tank in  10  our tank position
// - direction_tank      in   2   our tank direction
// - xpos_bullet, ypos_bullet in 10  our bullet position
// - tank_hit, obstacle_hit in 1  single-cycle event pulses from gun logic
// - direction_for_enemy in   3   bullet direction sent to enemy
// - hp_enemy            in   8   enemy HP as computed locally
// - tx_ready            in   1   UART TX idle, can accept a byte
// - tx_done             in   1   1-cycle pulse: current byte fully shifted out
// - tx_data             out  8   byte presented to UART TX
// - tx_start            out  1   1-cycle strobe: latch tx_data
// - pkt_active          out  1   packet in flight
// - overrun_cnt         out  8   saturating count of ticks dropped while busy
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; sticky events, pending flag, divider and seq bit cleared.
// - Tick generation:
//   - vsync is registered.
//   - Rising edge detected in cycle T.
//   - Divider counts edges and issues a tick on every FRAME_DIV-th edge.
// - Sticky events:
//   - tank_hit/obstacle_hit pulses set sticky bits.
//   - In the snapshot cycle, packet bit = sticky | pulse, and sticky is cleared.
//   - Events are never lost; events are reported at most once.
// - Packet layout (B0..B8):
//   - B0 = SYNC_BYTE
//   - B1 = xt[9:2]
//   - B2 = {xt[1:0], yt[9:4]}
//   - B3 = {yt[3:0], dir[1:0], xb[9:8]}
//   - B4 = xb[7:0]
//   - B5 = yb[9:2]
//   - B6 = {yb[1:0], hit, obs, dfe[2:0], seq}
//   - B7 = hp_enemy
//   - B8 = B1^B2^...^B7
// - seq toggles after every completed packet; starts at 0 after reset.
// - FSM states: IDLE -> LOAD -> SEND -> WAIT -> (SEND | IDLE)
//   - IDLE: on tick or pending, go to LOAD and clear pending.
//   - LOAD (1 cycle): snapshot all inputs into packet regs; byte_idx = 0; pkt_active = 1.
//   - SEND: when tx_ready, drive tx_data = B[byte_idx] with tx_start = 1 for exactly one cycle, then go to WAIT. Hold in SEND while tx_ready = 0.
//   - WAIT: on tx_done, increment byte_idx. If byte_idx was 8, toggle seq, drop pkt_active and go to IDLE; else go to SEND.
// - Latency: edge in cycle T gives LOAD at T+1 and the first tx_start at T+2 if tx_ready.
// - tx_data holds its value until the next tx_start.
// - Tick while pkt_active:
//   - First tick sets pending (one-deep).
//   - Each further tick while pending is already set increments overrun_cnt, saturating at 255.
//   - The pending packet starts in the cycle after the current packet returns to IDLE.
//   - Pending packet snapshots the inputs at its own LOAD, not at tick time.
// - Tick in the same cycle as the return to IDLE: treated as pending and served next cycle; no overrun.
// - tx_done outside WAIT is ignored.
// - Reset mid-packet: abort immediately; tx_start low; partial packet abandoned.
//   - The receiver resynchronises on SYNC_BYTE plus checksum.
// STRUCTURE
// - Shared include uart_frame_defs.vh holds:
//   - SYNC_BYTE default
//   - PKT_BYTES = 9
//   - FSM state encodings (IDLE/LOAD/SEND/WAIT)
//   - byte-index constants
// - The receiving-side decoder includes the same file.
// - One sub-module: frame_tick_gen. It holds the vsync register, edge detect and FRAME_DIV divider, and outputs a 1-cycle tick.
// - Packing and checksum are combinational from the snapshot regs, inside this module.
// TESTING
// - Reset/idle: rst = 0 for 3 cycles, then 1, no vsync -> all outputs 0, no tx_start.
// - Single packet, tx_ready = 1, tx_done 10 cycles after each start:
//   - Inputs: xt=10'h2AB, yt=10'h155, dir=2, xb=10'h3FF, yb=0, dfe=5, hp=8'h64, hits=0.
//   - Required bytes: A5, AA, D5, 5B, FF, 00, 0A, 64, then XOR of B1..B7.
//   - First tx_start at T+2 after the vsync edge.
// - Sticky events: hit pulse mid-packet -> absent from the current B6, present once in the next packet's B6[5], absent in the packet after.
// - Overrun: 3 ticks during one packet -> one pending packet follows back-to-back; overrun_cnt = 2. Then 300 more such overruns -> overrun_cnt = 255.
// - Back-pressure: hold tx_ready = 0 for 50 cycles in SEND -> tx_start stays low and tx_data is stable; the byte is sent once when ready.
// - FRAME_DIV = 3 plus reset mid-packet:
//   - 6 vsync edges -> exactly 2 packets.
//   - rst asserted after byte 4 -> tx_start drops at once; the next tick sends a full packet starting at A5 with seq = 0.

Source files
------------

// File: rtl/uart_frame_scheduler_pkg.sv
// rtl/uart_frame_scheduler_pkg.sv - shared constants, types and helpers for the UART frame scheduler
package uart_frame_scheduler_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         PKT_BYTES     = 9;

    // Byte positions inside a packet; the receiving-side decoder uses the same values
    localparam logic [3:0] IDX_SYNC      = 4'd0;
    localparam logic [3:0] IDX_CHECKSUM  = 4'(PKT_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    // Frame snapshot taken in LOAD; the packet bytes are packed from this
    typedef struct packed {
        logic [9:0] xt;
        logic [9:0] yt;
        logic [1:0] dir;
        logic [9:0] xb;
        logic [9:0] yb;
        logic       hit;
        logic       obs;
        logic [2:0] dfe;
        logic [7:0] hp;
    } snap_t;

    // XOR of the seven payload bytes B1..B7
    function automatic logic [7:0] xor_bytes(input logic [6:0][7:0] b);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 7; i++) begin
            acc = acc ^ b[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - vsync edge detector and frame divider producing a one-cycle tick
module frame_tick_gen #(
    parameter int FRAME_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vsync,
    output logic o_tick
);

    logic       r_vsync_q;
    logic       r_vsync_qq;
    logic [3:0] r_div_cnt;
    logic       w_edge;
    logic       w_div_last;

    assign w_edge     = r_vsync_q & ~r_vsync_qq;
    assign w_div_last = (r_div_cnt == 4'(FRAME_DIV - 1));
    assign o_tick     = w_edge & w_div_last;

    // Register vsync and keep the previous sample for rising-edge detection
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_vsync_q  <= 1'b0;
            r_vsync_qq <= 1'b0;
        end else begin
            r_vsync_q  <= i_vsync;
            r_vsync_qq <= r_vsync_q;
        end
    end

    // Count edges; the FRAME_DIV-th edge fires the tick and restarts the count
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div_cnt <= 4'd0;
        end else if (w_edge) begin
            r_div_cnt <= w_div_last ? 4'd0 : r_div_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - snapshots game state each frame and streams a 9-byte packet into uart_tx
module uart_frame_scheduler
    import uart_frame_scheduler_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         FRAME_DIV = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_vsync,
    input  logic [9:0] i_xpos_tank,
    input  logic [9:0] i_ypos_tank,
    input  logic [1:0] i_direction_tank,
    input  logic [9:0] i_xpos_bullet,
    input  logic [9:0] i_ypos_bullet,
    input  logic       i_tank_hit,
    input  logic       i_obstacle_hit,
    input  logic [2:0] i_direction_for_enemy,
    input  logic [7:0] i_hp_enemy,
    input  logic       i_tx_ready,
    input  logic       i_tx_done,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_pkt_active,
    output logic [7:0] o_overrun_cnt
);

    state_t          r_state;
    state_t          w_next;
    snap_t           r_snap;
    logic [3:0]      r_byte_idx;
    logic            r_seq;
    logic            r_pending;
    logic            r_hit_sticky;
    logic            r_obs_sticky;
    logic [7:0]      r_overrun;
    logic [7:0]      r_tx_data;

    logic            w_tick;
    logic [6:0][7:0] w_body;
    logic [7:0]      w_checksum;
    logic [7:0]      w_cur_byte;
    logic            w_tx_start;
    logic            w_byte_done;
    logic            w_pkt_done;

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vsync (i_vsync),
        .o_tick  (w_tick)
    );

    assign w_byte_done = (r_state == ST_WAIT) && i_tx_done;
    assign w_pkt_done  = w_byte_done && (r_byte_idx == IDX_CHECKSUM);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: one byte per SEND/WAIT round trip, checksum byte closes the packet
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_tick || r_pending) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_SEND;
            ST_SEND: if (i_tx_ready) w_next = ST_WAIT;
            ST_WAIT: if (i_tx_done) w_next = (r_byte_idx == IDX_CHECKSUM) ? ST_IDLE : ST_SEND;
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: start strobe only in SEND with the transmitter idle; data held between strobes
    always_comb begin
        w_tx_start   = (r_state == ST_SEND) && i_tx_ready;
        o_tx_start   = w_tx_start;
        o_pkt_active = (r_state != ST_IDLE);
        o_tx_data    = w_tx_start ? w_cur_byte : r_tx_data;
    end

    assign o_overrun_cnt = r_overrun;

    // Pack the snapshot into payload bytes B1..B7
    always_comb begin
        w_body[0] = r_snap.xt[9:2];
        w_body[1] = {r_snap.xt[1:0], r_snap.yt[9:4]};
        w_body[2] = {r_snap.yt[3:0], r_snap.dir, r_snap.xb[9:8]};
        w_body[3] = r_snap.xb[7:0];
        w_body[4] = r_snap.yb[9:2];
        w_body[5] = {r_snap.yb[1:0], r_snap.hit, r_snap.obs, r_snap.dfe, r_seq};
        w_body[6] = r_snap.hp;
    end

    assign w_checksum = xor_bytes(w_body);

    // Select the byte addressed by byte_idx: sync, payload, or checksum
    always_comb begin
        w_cur_byte = SYNC_BYTE;
        if (r_byte_idx == IDX_CHECKSUM) begin
            w_cur_byte = w_checksum;
        end else if (r_byte_idx != IDX_SYNC) begin
            w_cur_byte = w_body[r_byte_idx[2:0] - 3'd1];
        end
    end

    // Snapshot inputs in LOAD and advance the byte index / sequence bit as bytes complete
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_snap     <= '0;
            r_byte_idx <= IDX_SYNC;
            r_seq      <= 1'b0;
        end else begin
            if (r_state == ST_LOAD) begin
                r_snap.xt  <= i_xpos_tank;
                r_snap.yt  <= i_ypos_tank;
                r_snap.dir <= i_direction_tank;
                r_snap.xb  <= i_xpos_bullet;
                r_snap.yb  <= i_ypos_bullet;
                r_snap.hit <= r_hit_sticky | i_tank_hit;
                r_snap.obs <= r_obs_sticky | i_obstacle_hit;
                r_snap.dfe <= i_direction_for_enemy;
                r_snap.hp  <= i_hp_enemy;
                r_byte_idx <= IDX_SYNC;
            end else if (w_byte_done && !w_pkt_done) begin
                r_byte_idx <= r_byte_idx + 4'd1;
            end
            if (w_pkt_done) begin
                r_seq <= ~r_seq;
            end
        end
    end

    // Sticky event bits: set by pulses, consumed by the LOAD that reports them
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_hit_sticky <= 1'b0;
            r_obs_sticky <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_hit_sticky <= 1'b0;
            r_obs_sticky <= 1'b0;
        end else begin
            if (i_tank_hit)     r_hit_sticky <= 1'b1;
            if (i_obstacle_hit) r_obs_sticky <= 1'b1;
        end
    end

    // One-deep pending tick while busy; further ticks count as saturating overruns
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pending <= 1'b0;
            r_overrun <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            r_pending <= 1'b0;
        end else if (w_tick) begin
            if (!r_pending) begin
                r_pending <= 1'b1;
            end else if (r_overrun != 8'hFF) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end
    end

    // Hold the last presented byte on tx_data between start strobes
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tx_data <= 8'd0;
        end else if (w_tx_start) begin
            r_tx_data <= w_cur_byte;
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - self-checking bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

    typedef struct packed {
        logic [9:0] xt;
        logic [9:0] yt;
        logic [1:0] dir;
        logic [9:0] xb;
        logic [9:0] yb;
        logic [2:0] dfe;
        logic [7:0] hp;
    } inp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst3 = 1'b0;
    logic       vsync = 1'b0;
    logic [9:0] xt = '0, yt = '0, xb = '0, yb = '0;
    logic [1:0] dir = '0;
    logic [2:0] dfe = '0;
    logic [7:0] hp = '0;
    logic       tank_hit = 1'b0, obstacle_hit = 1'b0;
    logic       tx_ready = 1'b1, tx_ready3 = 1'b1;
    logic       tx_done = 1'b0, tx_done3 = 1'b0;

    logic [7:0] tx_data, tx_data3, overrun, overrun3;
    logic       tx_start, tx_start3, pkt_active, pkt_active3;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         cnt1 = 0, cnt3 = 0;
    logic [7:0] q1[$];
    int         qc1[$];
    logic [7:0] q3[$];

    always #5 clk = ~clk;

    uart_frame_scheduler #(.SYNC_BYTE(8'hA5), .FRAME_DIV(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_vsync(vsync),
        .i_xpos_tank(xt), .i_ypos_tank(yt), .i_direction_tank(dir),
        .i_xpos_bullet(xb), .i_ypos_bullet(yb),
        .i_tank_hit(tank_hit), .i_obstacle_hit(obstacle_hit),
        .i_direction_for_enemy(dfe), .i_hp_enemy(hp),
        .i_tx_ready(tx_ready), .i_tx_done(tx_done),
        .o_tx_data(tx_data), .o_tx_start(tx_start),
        .o_pkt_active(pkt_active), .o_overrun_cnt(overrun)
    );

    uart_frame_scheduler #(.SYNC_BYTE(8'hA5), .FRAME_DIV(3)) dut3 (
        .i_clk(clk), .i_rst(rst3), .i_vsync(vsync),
        .i_xpos_tank(xt), .i_ypos_tank(yt), .i_direction_tank(dir),
        .i_xpos_bullet(xb), .i_ypos_bullet(yb),
        .i_tank_hit(tank_hit), .i_obstacle_hit(obstacle_hit),
        .i_direction_for_enemy(dfe), .i_hp_enemy(hp),
        .i_tx_ready(tx_ready3), .i_tx_done(tx_done3),
        .o_tx_data(tx_data3), .o_tx_start(tx_start3),
        .o_pkt_active(pkt_active3), .o_overrun_cnt(overrun3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Byte loggers and UART models: tx_done pulses 10 cycles after each start
    always @(negedge clk) begin
        if (tx_start) begin
            q1.push_back(tx_data);
            qc1.push_back(cyc);
        end
        if (tx_start3) q3.push_back(tx_data3);
        tx_done = 1'b0;
        if (cnt1 > 0) begin
            cnt1 = cnt1 - 1;
            if (cnt1 == 0) tx_done = 1'b1;
        end
        if (tx_start) cnt1 = 10;
        tx_done3 = 1'b0;
        if (!rst3) cnt3 = 0;
        else if (cnt3 > 0) begin
            cnt3 = cnt3 - 1;
            if (cnt3 == 0) tx_done3 = 1'b1;
        end
        if (tx_start3) cnt3 = 10;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick(); tick();
        vsync = 1'b0;
        tick(); tick();
    endtask

    task automatic apply(input inp_t s);
        xt = s.xt; yt = s.yt; dir = s.dir; xb = s.xb; yb = s.yb; dfe = s.dfe; hp = s.hp;
    endtask

    function automatic inp_t rand_inp();
        inp_t s;
        s.xt = 10'($urandom); s.yt = 10'($urandom); s.dir = 2'($urandom);
        s.xb = 10'($urandom); s.yb = 10'($urandom); s.dfe = 3'($urandom);
        s.hp = 8'($urandom);
        return s;
    endfunction

    // Reference packet: the payload is the field bit-stream cut into bytes
    function automatic logic [8:0][7:0] model_pkt(input inp_t s, input logic hit, input logic obs,
                                                 input logic seq);
        logic [55:0]     stream;
        logic [8:0][7:0] p;
        stream = {s.xt, s.yt, s.dir, s.xb, s.yb, hit, obs, s.dfe, seq, s.hp};
        p[0] = 8'hA5;
        p[8] = 8'h00;
        for (int i = 1; i <= 7; i++) begin
            p[i] = stream[55 - 8 * (i - 1) -: 8];
            p[8] = p[8] ^ p[i];
        end
        return p;
    endfunction

    task automatic wait_bytes1(input int n, input string tag);
        int b = 0;
        while (q1.size() < n && b < 3000) begin tick(); b++; end
        check(tag, 32'(b < 3000), 32'd1);
    endtask

    task automatic wait_pkt1(input int n, input string tag);
        int b = 0;
        while ((q1.size() < n || pkt_active) && b < 3000) begin tick(); b++; end
        check(tag, 32'(b < 3000), 32'd1);
    endtask

    task automatic wait_pkt3(input int n, input string tag);
        int b = 0;
        while ((q3.size() < n || pkt_active3) && b < 3000) begin tick(); b++; end
        check(tag, 32'(b < 3000), 32'd1);
    endtask

    task automatic cmp1(input int base, input logic [8:0][7:0] exp, input string tag);
        logic [7:0] v;
        for (int i = 0; i < 9; i++) begin
            v = (base + i < q1.size()) ? q1[base + i] : 8'hXX;
            check($sformatf("%s_b%0d", tag, i), 32'(v), 32'(exp[i]));
        end
    endtask

    task automatic cmp3(input int base, input logic [8:0][7:0] exp, input string tag);
        logic [7:0] v;
        for (int i = 0; i < 9; i++) begin
            v = (base + i < q3.size()) ? q3[base + i] : 8'hXX;
            check($sformatf("%s_b%0d", tag, i), 32'(v), 32'(exp[i]));
        end
    endtask

    initial begin
        inp_t            s;
        logic [8:0][7:0] exp;
        logic [8:0][7:0] lit;
        logic            exp_seq;
        logic [7:0]      prev_last;
        int              base, c0, bad_start, bad_data, b;

        // Reset and idle
        tick(); tick(); tick();
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_pkt_active", 32'(pkt_active), 32'd0);
        rst = 1'b1;
        repeat (5) tick();
        check("idle_tx_start", 32'(tx_start), 32'd0);
        check("idle_tx_data", 32'(tx_data), 32'd0);
        check("idle_pkt_active", 32'(pkt_active), 32'd0);
        check("idle_overrun", 32'(overrun), 32'd0);
        check("idle_no_bytes", 32'(q1.size()), 32'd0);

        // Directed packet with known byte values and latency
        s = '{xt: 10'h2AB, yt: 10'h155, dir: 2'd2, xb: 10'h3FF, yb: 10'h000, dfe: 3'd5, hp: 8'h64};
        apply(s);
        vsync = 1'b1;
        c0 = cyc;
        tick(); tick();
        vsync = 1'b0;
        wait_pkt1(9, "dir_wait");
        lit = {8'hB5, 8'h64, 8'h0A, 8'h00, 8'hFF, 8'h5B, 8'hD5, 8'hAA, 8'hA5};
        cmp1(0, lit, "dir_lit");
        cmp1(0, model_pkt(s, 1'b0, 1'b0, 1'b0), "dir_model");
        check("dir_latency", 32'((qc1.size() > 0) ? qc1[0] - c0 : -1), 32'd3);
        check("dir_byte_gap", 32'((qc1.size() > 1) ? qc1[1] - qc1[0] : -1), 32'd11);
        exp_seq = 1'b1;

        // Random packets
        for (int k = 0; k < 4; k++) begin
            s = rand_inp();
            apply(s);
            base = q1.size();
            pulse_vsync();
            wait_pkt1(base + 9, "rand_wait");
            cmp1(base, model_pkt(s, 1'b0, 1'b0, exp_seq), $sformatf("rand%0d", k));
            exp_seq = ~exp_seq;
        end

        // Sticky events: pulsed mid-packet, reported once in the next packet
        s = rand_inp();
        apply(s);
        base = q1.size();
        pulse_vsync();
        wait_bytes1(base + 2, "stk_mid");
        tank_hit = 1'b1; tick(); tank_hit = 1'b0;
        tick(); tick();
        obstacle_hit = 1'b1; tick(); obstacle_hit = 1'b0;
        wait_pkt1(base + 9, "stk_wait1");
        cmp1(base, model_pkt(s, 1'b0, 1'b0, exp_seq), "stk_p1");
        exp_seq = ~exp_seq;
        for (int k = 0; k < 2; k++) begin
            base = q1.size();
            pulse_vsync();
            wait_pkt1(base + 9, "stk_wait");
            exp = model_pkt(s, (k == 0), (k == 0), exp_seq);
            cmp1(base, exp, $sformatf("stk_p%0d", k + 2));
            exp_seq = ~exp_seq;
        end
        prev_last = exp[8];

        // Back-pressure: tx_ready low for 50 cycles while in SEND
        tx_ready = 1'b0;
        s = rand_inp();
        apply(s);
        base = q1.size();
        pulse_vsync();
        bad_start = 0;
        bad_data = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (tx_start !== 1'b0) bad_start++;
            if (tx_data !== prev_last) bad_data++;
        end
        check("bp_start_low", 32'(bad_start), 32'd0);
        check("bp_data_stable", 32'(bad_data), 32'd0);
        check("bp_pkt_active", 32'(pkt_active), 32'd1);
        check("bp_no_bytes", 32'(q1.size() - base), 32'd0);
        tx_ready = 1'b1;
        wait_pkt1(base + 9, "bp_wait");
        cmp1(base, model_pkt(s, 1'b0, 1'b0, exp_seq), "bp");
        check("bp_sent_once", 32'(q1.size() - base), 32'd9);
        exp_seq = ~exp_seq;

        // Overrun: three ticks during one packet give one pending packet and two overruns
        s = rand_inp();
        apply(s);
        base = q1.size();
        pulse_vsync();
        wait_bytes1(base + 2, "ovr_mid");
        pulse_vsync(); pulse_vsync(); pulse_vsync();
        wait_pkt1(base + 18, "ovr_wait");
        cmp1(base, model_pkt(s, 1'b0, 1'b0, exp_seq), "ovr_p1");
        cmp1(base + 9, model_pkt(s, 1'b0, 1'b0, ~exp_seq), "ovr_p2");
        check("ovr_back2back_gap",
              32'((qc1.size() > base + 9) ? qc1[base + 9] - qc1[base + 8] : -1), 32'd13);
        check("ovr_cnt2", 32'(overrun), 32'd2);
        check("ovr_total_bytes", 32'(q1.size() - base), 32'd18);

        // Saturation: a long burst of ticks pushes the overrun count well past 255
        for (int k = 0; k < 330; k++) pulse_vsync();
        wait_pkt1(0, "sat_wait");
        check("ovr_saturated", 32'(overrun), 32'd255);

        // FRAME_DIV = 3: six edges give two packets
        rst3 = 1'b1;
        tick(); tick();
        check("d3_idle_active", 32'(pkt_active3), 32'd0);
        s = rand_inp();
        apply(s);
        for (int k = 0; k < 6; k++) begin
            pulse_vsync();
            wait_pkt3(0, "d3_wait");
        end
        check("d3_two_packets", 32'(q3.size()), 32'd18);
        cmp3(0, model_pkt(s, 1'b0, 1'b0, 1'b0), "d3_p1");
        cmp3(9, model_pkt(s, 1'b0, 1'b0, 1'b1), "d3_p2");

        // Reset mid-packet after byte 4, then a clean packet from A5 with seq 0
        pulse_vsync(); pulse_vsync(); pulse_vsync();
        b = 0;
        while (!(q3.size() == 22 && tx_start3 === 1'b1) && b < 3000) begin tick(); b++; end
        check("d3_reach_byte5", 32'(b < 3000), 32'd1);
        rst3 = 1'b0;
        #1;
        check("d3_rst_tx_start", 32'(tx_start3), 32'd0);
        check("d3_rst_pkt_active", 32'(pkt_active3), 32'd0);
        check("d3_rst_tx_data", 32'(tx_data3), 32'd0);
        tick(); tick();
        rst3 = 1'b1;
        q3.delete();
        s = rand_inp();
        apply(s);
        pulse_vsync(); pulse_vsync(); pulse_vsync();
        wait_pkt3(9, "d3_after_rst_wait");
        cmp3(0, model_pkt(s, 1'b0, 1'b0, 1'b0), "d3_after_rst");
        check("d3_after_rst_count", 32'(q3.size()), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
